z80_bus_responder: RTL
======================

# z80_bus_responder

Parametrised, clocked memory and I/O responder for the tv80s bus, used as the standard target behind the CPU in instruction-level benches and FPGA smoke builds. It replaces ad-hoc memory arrays with one synthesisable model. The model adds programmable wait-state insertion per address space and interrupt-acknowledge vectoring. It also captures every CPU write into a FIFO log, so checkers can compare writes in order without probing arrays.

## Interface
Parameters:
- ADDR_W, 16, memory address width; memory depth is 2**ADDR_W bytes.
- IO_ADDR_W, 8, I/O address width, taken from A[IO_ADDR_W-1:0].
- MEM_WAIT, 0, wait states inserted on memory accesses (0..15).
- IO_WAIT, 1, wait states inserted on I/O accesses (0..15).
- INTACK_VEC, 8'hFF, byte returned on interrupt-acknowledge cycles.
- LOG_DEPTH, 16, write-log FIFO depth; power of two, at least 2.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: synchronous reset, active-high.
- mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, in, 1 each: CPU bus strobes.
- A, in, ADDR_W: CPU address.
- cpu_dout, in, 8: CPU write data.
- cpu_di, out, 8: registered read data to the CPU.
- wait_n, out, 1: registered wait request to the CPU.
- ld_en, in, 1: backdoor load strobe.
- ld_io, in, 1: backdoor target; 1 selects I/O space, 0 selects memory.
- ld_addr, in, ADDR_W: backdoor address.
- ld_data, in, 8: backdoor data.
- log_valid, out, 1: the FIFO head entry is valid.
- log_ready, in, 1: pop request.
- log_addr, out, ADDR_W: head entry address.
- log_data, out, 8: head entry data.
- log_is_io, out, 1: head entry was an I/O write.
- log_count, out, $clog2(LOG_DEPTH)+1: current FIFO occupancy.
- log_overflow, out, 1: sticky flag, set when a write entry is dropped.

## Operation
- Request qualification:
  - mem_req = !mreq_n & rfsh_n & (!rd_n | !wr_n). Refresh cycles are ignored.
  - io_req = !iorq_n & m1_n & (!rd_n | !wr_n).
  - ack_req = !iorq_n & !m1_n. Interrupt acknowledge is treated as a read.
- State machine: IDLE, WAIT, HOLD.
  - IDLE:
    - Any request with n = 0 (n = MEM_WAIT or IO_WAIT by space): perform the access on this edge, then go to HOLD.
    - Any request with n > 0: load cnt <= n-1, go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt == 0: perform the access, go to HOLD.
  - HOLD: stay until rd_n & wr_n are both high, then go to IDLE.
- Request kind and address are latched in IDLE. The write/read decision is re-sampled at the access edge, because tv80 asserts wr_n one cycle after mreq_n.
- Access:
  - Memory read: cpu_di <= mem[A].
  - I/O read: cpu_di <= io[A[IO_ADDR_W-1:0]].
  - ack read: cpu_di <= INTACK_VEC.
  - Write: the array is written with cpu_dout and the entry {A, cpu_dout, is_io} is pushed into the log.
- Backdoor load: writes the selected array on any cycle and never touches the log. If a bus write hits the same address and space on the same edge, the bus write wins.
- Log FIFO:
  - Pop when log_valid & log_ready.
  - Push and pop on the same edge while full: both occur, count unchanged.
  - Push while full without a pop: the entry is dropped and log_overflow <= 1.
  - Pop while empty: ignored.
  - Pointers wrap modulo LOG_DEPTH.
- Memory and I/O arrays are not cleared by reset.

## Timing
- Reset values:
  - state = IDLE, wait_n = 1, cpu_di = 8'hFF.
  - log_valid = 0, log_count = 0, log_overflow = 0.
  - log_addr, log_data and log_is_io = 0.
- Reset asserted mid-transaction: the in-flight access is abandoned. If the access edge coincides with reset, there is no array write and no log push.
- wait_n is 0 for exactly n consecutive cycles, starting the cycle after the request is seen in IDLE.
- Read latency: cpu_di is valid n+1 edges after the request edge and holds until the next access.
- Write visibility:
  - The array is updated at the access edge.
  - log_valid rises on the following edge when the FIFO was empty.
  - log_count updates on the edge after push or pop.
- Back-to-back requests: a new request is accepted only from IDLE, so at least one cycle with both strobes high separates accesses.

## Test plan
- Memory read, MEM_WAIT=0: preload mem[16'h0003]=8'hCB, CPU reads 0003 → cpu_di=8'hCB one edge later, wait_n never low.
- I/O write, IO_WAIT=2: CPU OUT (8'h5A),8'h77 → wait_n low exactly 2 cycles; io[5A]=77; log entry {005A,77,1}; log_count 0→1.
- Instruction DD CB A4 CB with IX=16'hA447, mem[A3EB]=8'h73: tv80s completes with mem[A3EB]=8'h73 (bit 1 already set); log holds exactly one entry, {A3EB,73,0}.
- Log full: LOG_DEPTH=4, 5 writes with log_ready=0 → log_count=4, log_overflow=1, head is the first write. Then a push and a pop on the same edge while full → count stays 4.
- Interrupt ack: m1_n=0, iorq_n=0 → cpu_di=INTACK_VEC (8'hFF), no log push.
- Reset during a WAIT with IO_WAIT=3, asserted on cycle 2 → wait_n=1 and state IDLE next edge; the target address is unchanged, log_count=0.

Source files
------------

// File: rtl/z80_bus_responder.sv
// Clocked memory/I-O target for the tv80s bus: per-space wait states,
// interrupt-acknowledge vectoring and an in-order log of every CPU write.
module z80_bus_responder #(
    parameter int         ADDR_W     = 16,
    parameter int         IO_ADDR_W  = 8,
    parameter int         MEM_WAIT   = 0,
    parameter int         IO_WAIT    = 1,
    parameter logic [7:0] INTACK_VEC = 8'hFF,
    parameter int         LOG_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mreq_n,
    input  logic                         iorq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic                         m1_n,
    input  logic                         rfsh_n,
    input  logic [ADDR_W-1:0]            A,
    input  logic [7:0]                   cpu_dout,
    output logic [7:0]                   cpu_di,
    output logic                         wait_n,
    input  logic                         ld_en,
    input  logic                         ld_io,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [7:0]                   ld_data,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [ADDR_W-1:0]            log_addr,
    output logic [7:0]                   log_data,
    output logic                         log_is_io,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow
);
    localparam int PTR_W   = $clog2(LOG_DEPTH);
    localparam int ENTRY_W = ADDR_W + 9;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

    state_t state, state_nxt;

    logic [7:0]         mem_arr [2**ADDR_W];
    logic [7:0]         io_arr  [2**IO_ADDR_W];
    logic [ENTRY_W-1:0] log_mem [LOG_DEPTH];

    logic               mem_req, io_req, ack_req, any_req;
    logic [3:0]         req_wait, cnt;
    logic               lat_io, lat_ack;
    logic [ADDR_W-1:0]  lat_addr;
    logic               do_access, acc_go, acc_io, acc_ack, acc_wr;
    logic [ADDR_W-1:0]  acc_addr;
    logic [7:0]         rd_byte;

    logic               push_p0;
    logic [ENTRY_W-1:0] entry_p0;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               log_full, pop, push_ok;

    always_comb begin
        mem_req   = !mreq_n & rfsh_n & (!rd_n | !wr_n);
        io_req    = !iorq_n & m1_n & (!rd_n | !wr_n);
        ack_req   = !iorq_n & !m1_n;
        any_req   = mem_req | io_req | ack_req;
        // Interrupt acknowledge is an iorq cycle, so it takes the I/O wait count.
        req_wait  = (io_req | ack_req) ? 4'(IO_WAIT) : 4'(MEM_WAIT);

        state_nxt = state;
        do_access = 1'b0;
        acc_io    = lat_io;
        acc_ack   = lat_ack;
        acc_addr  = lat_addr;
        case (state)
            ST_IDLE: begin
                acc_io   = io_req | ack_req;
                acc_ack  = ack_req;
                acc_addr = A;
                if (any_req) begin
                    if (req_wait == 4'd0) begin
                        do_access = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rd_n && wr_n) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // wr_n is re-sampled here because tv80 drops it a cycle after mreq_n.
        acc_wr  = !wr_n & !acc_ack;
        acc_go  = do_access & !reset;
        rd_byte = acc_ack ? INTACK_VEC :
                  acc_io  ? io_arr[acc_addr[IO_ADDR_W-1:0]] : mem_arr[acc_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            wait_n  <= 1'b1;
            cpu_di  <= 8'hFF;
            cnt     <= 4'd0;
            push_p0 <= 1'b0;
        end else begin
            state   <= state_nxt;
            wait_n  <= (state_nxt != ST_WAIT);
            push_p0 <= acc_go & acc_wr;
            if (acc_go && !acc_wr) cpu_di <= rd_byte;
            if (state == ST_IDLE && any_req) cnt <= req_wait - 4'd1;
            else if (state == ST_WAIT)       cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && any_req) begin
            lat_io   <= io_req | ack_req;
            lat_ack  <= ack_req;
            lat_addr <= A;
        end
        entry_p0 <= {acc_addr, cpu_dout, acc_io};
    end

    // Backdoor first so a same-edge bus write to the same location wins.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (ld_io) io_arr[ld_addr[IO_ADDR_W-1:0]] <= ld_data;
            else       mem_arr[ld_addr]               <= ld_data;
        end
        if (acc_go && acc_wr) begin
            if (acc_io) io_arr[acc_addr[IO_ADDR_W-1:0]] <= cpu_dout;
            else        mem_arr[acc_addr]               <= cpu_dout;
        end
    end

    // ---- write log FIFO, fed one edge after the access ----
    always_comb begin
        log_full  = (log_count == (PTR_W+1)'(LOG_DEPTH));
        log_valid = (log_count != '0);
        pop       = log_valid & log_ready;
        push_ok   = push_p0 & (!log_full | pop);
        {log_addr, log_data, log_is_io} = log_valid ? log_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            log_count    <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   log_count <= log_count + 1'b1;
                2'b01:   log_count <= log_count - 1'b1;
                default: ;
            endcase
            if (push_p0 && log_full && !pop) log_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) log_mem[wr_ptr] <= entry_p0;
    end
endmodule
